ether_rx: RTL and testbench

RMII receive front end for the Ethernet path. It samples crsdv/rxd on the 50 MHz RMII clock and validates the preamble and SFD. Only payload dibits (destination MAC through FCS) are forwarded on an axiiv/axiid-style valid/data stream, which feeds the FCS checker (cksum) and the bit-order/aggregation stages. It also flags start, end and malformed frames so downstream stages can reset or kill.

---
 rtl/eth_pkg.sv | 19 +
 rtl/ether_rx_if.sv | 22 ++
 rtl/ether_rx.sv | 94 +++++++++
 tb/tb_ether_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the RMII Ethernet receive path (rx front end, cksum, bench).
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;
    localparam int unsigned MIN_PREAMBLE   = 28;
    localparam int unsigned MAX_DIBITS     = 6104;

    localparam int unsigned PCOUNT_W = 6;
    localparam int unsigned DCOUNT_W = $clog2(MAX_DIBITS + 1);

endpackage

// File: rtl/ether_rx_if.sv
// RMII receive dibits in, payload dibit stream plus frame markers out.
interface ether_rx_if;

    logic       crsdv;
    logic [1:0] rxd;
    logic       axiov;
    logic [1:0] axiod;
    logic       sof;
    logic       eof;
    logic       err;

    modport master (
        output crsdv, rxd,
        input  axiov, axiod, sof, eof, err
    );

    modport slave (
        input  crsdv, rxd,
        output axiov, axiod, sof, eof, err
    );

endinterface

// File: rtl/ether_rx.sv
// RMII receive front end: validates preamble/SFD and forwards payload dibits
// (destination MAC through FCS) with sof/eof/err markers, all registered.
module ether_rx
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ether_rx_if.slave  rx
);

    localparam logic [PCOUNT_W-1:0] PMin = PCOUNT_W'(MIN_PREAMBLE);
    localparam logic [PCOUNT_W-1:0] POne = PCOUNT_W'(1);
    localparam logic [DCOUNT_W-1:0] DMax = DCOUNT_W'(MAX_DIBITS);
    localparam logic [DCOUNT_W-1:0] DOne = DCOUNT_W'(1);

    rx_state_t             state_q;
    logic [PCOUNT_W-1:0]   pcount_q;
    logic [DCOUNT_W-1:0]   dcount_q;
    logic                  axiov_q;
    logic [1:0]            axiod_q;
    logic                  sof_q;
    logic                  eof_q;
    logic                  err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pcount_q <= '0;
            dcount_q <= '0;
            axiov_q  <= 1'b0;
            axiod_q  <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            axiov_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
            axiod_q <= rx.rxd;
            unique case (state_q)
                IDLE: begin
                    if (rx.crsdv) begin
                        if (rx.rxd == PREAMBLE_DIBIT) begin
                            state_q  <= PREAMBLE;
                            pcount_q <= POne;
                        end else begin
                            state_q <= DROP;
                            err_q   <= 1'b1;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!rx.crsdv) begin
                        state_q <= IDLE;
                    end else if (rx.rxd == PREAMBLE_DIBIT) begin
                        if (pcount_q != '1) pcount_q <= pcount_q + POne;
                    end else if (rx.rxd == SFD_DIBIT && pcount_q >= PMin) begin
                        state_q  <= DATA;
                        dcount_q <= '0;
                    end else begin
                        state_q <= DROP;
                        err_q   <= 1'b1;
                    end
                end
                DATA: begin
                    if (!rx.crsdv) begin
                        state_q <= IDLE;
                        eof_q   <= 1'b1;
                    end else if (dcount_q == DMax) begin
                        // Overlength: the dibit that would exceed the limit is not forwarded.
                        state_q <= DROP;
                        err_q   <= 1'b1;
                    end else begin
                        axiov_q  <= 1'b1;
                        sof_q    <= (dcount_q == '0);
                        dcount_q <= dcount_q + DOne;
                    end
                end
                DROP: begin
                    if (!rx.crsdv) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx.axiov = axiov_q;
    assign rx.axiod = axiod_q;
    assign rx.sof   = sof_q;
    assign rx.eof   = eof_q;
    assign rx.err   = err_q;

endmodule

// File: tb/tb_ether_rx.sv
// Bench for ether_rx: frame-level reference model turns each carrier burst into
// the expected per-cycle output trace, compared one cycle after each sample edge.
module tb_ether_rx;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ether_rx_if bus ();

    ether_rx dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] burst [$];
    // Expected trace entry: {axiov, axiod, sof, eof, err}
    logic [5:0] expv  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] observed();
        return {bus.axiov, (bus.axiov ? bus.axiod : 2'b00), bus.sof, bus.eof, bus.err};
    endfunction

    function automatic logic [5:0] raw_out();
        return {bus.axiov, bus.axiod, bus.sof, bus.eof, bus.err};
    endfunction

    // Frame rules applied to a whole burst starting from idle: the leading run of
    // preamble dibits decides acceptance; payload is whatever follows the SFD.
    task automatic model(input int gap);
        int n;
        int k;
        int p;
        int fwd;
        n = burst.size();
        k = 0;
        expv.delete();
        for (int i = 0; i < n + gap + 1; i++) expv.push_back('0);
        while (k < n && burst[k] == PREAMBLE_DIBIT) k++;
        if (k < n) begin
            if (burst[k] == SFD_DIBIT && k >= int'(MIN_PREAMBLE)) begin
                p   = n - k - 1;
                fwd = (p > int'(MAX_DIBITS)) ? int'(MAX_DIBITS) : p;
                for (int j = 0; j < fwd; j++)
                    expv[k + 1 + j] = {1'b1, burst[k + 1 + j], (j == 0), 2'b00};
                if (p > int'(MAX_DIBITS)) expv[k + 1 + fwd] = 6'b000001;
                else                      expv[n]           = 6'b000010;
            end else begin
                expv[k] = 6'b000001;
            end
        end
    endtask

    task automatic drive_check(input string tag, input int n, input int total);
        for (int i = 0; i < total; i++) begin
            bus.crsdv = (i < n);
            bus.rxd   = (i < n) ? burst[i] : 2'($urandom);
            @(posedge clk);
            #1;
            check(tag, 32'(observed()), 32'(expv[i]));
        end
    endtask

    task automatic run(input string tag, input int gap);
        int n;
        n = burst.size();
        model(gap);
        drive_check(tag, n, n + gap);
    endtask

    task automatic push_n(input int cnt, input logic [1:0] d);
        for (int i = 0; i < cnt; i++) burst.push_back(d);
    endtask

    task automatic push_rand(input int cnt);
        for (int i = 0; i < cnt; i++) burst.push_back(2'($urandom));
    endtask

    initial begin
        int len;
        int kind;
        logic [1:0] bad;

        rst       = 1'b1;
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 32'(raw_out()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        burst.delete();
        push_n(31, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        for (int i = 0; i < 8; i++) burst.push_back(2'(i));
        run("valid", 2);

        burst.delete();
        push_n(20, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        run("short_pre", 2);

        burst.delete();
        push_n(15, PREAMBLE_DIBIT);
        burst.push_back(2'b10);
        push_n(15, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        run("corrupt_pre", 2);

        burst.delete();
        push_n(int'(MIN_PREAMBLE), PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(4);
        run("pre_min", 1);

        burst.delete();
        push_n(int'(MIN_PREAMBLE) - 1, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(4);
        run("pre_min_m1", 1);

        burst.delete();
        push_n(30, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        run("zero_payload", 1);

        burst.delete();
        push_n(70, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(5);
        run("pre_saturate", 1);

        burst.delete();
        push_n(28, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(int'(MAX_DIBITS));
        run("max_len", 1);

        burst.delete();
        push_n(28, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(int'(MAX_DIBITS) + 1);
        run("over_len", 2);

        for (int f = 0; f < 2; f++) begin
            burst.delete();
            push_n(31, PREAMBLE_DIBIT);
            burst.push_back(SFD_DIBIT);
            push_rand(4);
            run("back2back", 1);
        end

        // Reset while a frame is in its payload; the tail is re-parsed from idle.
        burst.delete();
        push_n(31, PREAMBLE_DIBIT);
        burst.push_back(SFD_DIBIT);
        push_rand(3);
        model(0);
        drive_check("rst_pre", burst.size(), burst.size());
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 32'(raw_out()), 32'd0);
        bus.crsdv = 1'b1;
        bus.rxd   = 2'($urandom);
        @(posedge clk);
        #1;
        check("rst_hold", 32'(raw_out()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        burst.delete();
        burst.push_back(2'b10);
        push_rand(5);
        run("rst_tail", 2);

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(24, 40);
            burst.delete();
            if (kind == 2) burst.push_back(2'($urandom));
            push_n(len, PREAMBLE_DIBIT);
            if (kind == 0) begin
                bad = 2'($urandom_range(0, 2));
                if (bad == PREAMBLE_DIBIT) bad = 2'b10;
                burst[$urandom_range(0, len - 1)] = bad;
            end
            if (kind == 1) burst.push_back(2'($urandom));
            else           burst.push_back(SFD_DIBIT);
            push_rand($urandom_range(0, 50));
            run("random", $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
